pio_loader: RTL and testbench
=============================

Name: pio_loader

Overview:
- Sequencer that streams a PIO program and a configuration list into the `pio` block's `action/din/index/mindex` load port. It is the parametrised replacement for the hard-wired program/config state machine in the board top level.
- Program and config words come from external synchronous ROMs or RAMs with one-cycle read latency.
- Loading starts on a `start` pulse, can be re-run, and can be aborted.
- Supports N state machines, per-entry machine selection, and broadcast config entries that are replicated to every machine.

Parameters:
- PROG_DEPTH, 32, instruction memory depth; index width PW = $clog2(PROG_DEPTH).
- CONF_DEPTH, 32, config list depth; address width CW = $clog2(CONF_DEPTH).
- NUM_SM, 4, number of PIO state machines, ≥2; SW = $clog2(NUM_SM).
- CONF_W, 37+SW, config entry width: [CONF_W-1] = broadcast, [35+SW:36] = mindex, [35:32] = action, [31:0] = din.

Ports:
- clk  in  1  system clock
- n_reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to begin loading; sampled only in IDLE
- abort  in  1  synchronous abort; stops loading
- prog_len  in  PW+1  number of instructions to load; 0..PROG_DEPTH
- conf_len  in  CW+1  number of config entries; 0..CONF_DEPTH
- prog_rd_addr  out  PW  program memory read address
- prog_rd_data  in  16  program word; valid the cycle after its address
- conf_rd_addr  out  CW  config memory read address
- conf_rd_data  in  CONF_W  config entry; valid the cycle after its address
- action  out  4  pio action; 0 = no-op
- din  out  32  pio data
- index  out  5  instruction slot for action 1
- mindex  out  SW  target state machine
- busy  out  1  high while loading
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset (n_reset = 0 at a clock edge): all outputs, addresses and state are 0; the FSM is in IDLE.
- FSM states are IDLE, PROG, CONF, DRAIN and FIN.
- IDLE:
  - action = 0.
  - When start = 1, lengths are latched; a length above its depth is clamped to the depth.
  - Next state is PROG if prog_len ≠ 0, else CONF if conf_len ≠ 0, else FIN.
- PROG:
  - Presents prog_rd_addr = 0, 1, … on consecutive cycles.
  - After the last address (prog_len−1) the FSM moves directly to CONF, or to DRAIN if conf_len = 0.
- Program output pipeline:
  - Address A is presented in cycle t; action = 1, din = {16'b0, prog_rd_data}, index = A, mindex = 0 are registered and visible in cycle t+2.
  - Throughput is one word per cycle with no gaps.
- CONF:
  - Presents conf_rd_addr = 0, 1, …, entering in the cycle after the last program address; same 2-cycle pipeline.
  - For a non-broadcast entry, the outputs are action, din and mindex from the entry fields, and index = 0.
  - For a broadcast entry (bit CONF_W-1 = 1):
    - The entry is emitted NUM_SM times on consecutive cycles with mindex = 0..NUM_SM−1; the entry's own mindex field is ignored.
    - conf_rd_addr holds (advances stall) so the following entry is issued directly after the last replica.
    - Each broadcast entry adds NUM_SM−1 cycles.
- DRAIN: waits until the final output cycle has been presented.
- FIN: done = 1 for one cycle, busy = 0, then the FSM returns to IDLE.
- action returns to 0 in the cycle after the last output and whenever no word is being issued.
- busy:
  - High from the cycle after start is accepted through the last output cycle.
  - Low in IDLE and FIN.
  - With both lengths 0, busy stays low and done pulses in the cycle after start.
- start while not in IDLE is ignored.
- abort = 1 in any non-IDLE state:
  - The next state is IDLE and action = 0 from the next cycle; busy falls.
  - No done pulse; in-flight pipeline words are discarded.
  - abort has priority over start in the same cycle.
- n_reset low mid-load behaves like abort and also clears all outputs.
- Address counters never wrap past len−1; prog_len = PROG_DEPTH issues indices 0..PROG_DEPTH−1.

Test Plan:
1. Basic load: NUM_SM = 4, prog_len = 12, conf_len = 5, no broadcast, start at cycle 0.
   - Cycles 3..14: action = 1 with index 0..11 matching ROM contents.
   - Cycles 15..19: config actions with the entries' mindex values.
   - Cycle 20: done = 1.
   - busy is high for cycles 1..19.
2. Broadcast entry {1, 2'd2, 4'h6, 32'h1} as the only entry, with prog_len = 0.
   - Outputs action = 6, din = 1 with mindex 0, 1, 2, 3 on cycles 3..6; done on cycle 7.
3. Length edge cases:
   - prog_len = 0, conf_len = 0: busy never rises, done pulses at cycle 1.
   - prog_len = 40: clamped, exactly 32 program writes with indices 0..31.
4. Abort at cycle 8 of the basic load:
   - action = 0 from cycle 9 onward; busy = 0 at cycle 9; no done.
   - A new start at cycle 10 reloads from index 0.
5. n_reset low at cycle 6 for one cycle: all outputs are 0 at cycle 7 and the FSM stays in IDLE.
6. Re-start pulse held during busy: no restart and no extra writes; the sequence matches scenario 1 exactly.

Source files
------------

// File: rtl/pio_loader.sv
// pio_loader: streams a PIO program followed by a configuration list into the
// pio block's load port (action/din/index/mindex). Both sources are
// synchronous memories with one-cycle read latency. Every word goes through a
// two-stage pipeline: the address is presented in cycle t, the read data is
// valid in t+1, and the registered load-port outputs appear in t+2.
// A broadcast config entry is replayed once per state machine. While it is
// replayed, the config address holds so the next entry follows directly.
module pio_loader #(
    parameter int PROG_DEPTH = 32,
    parameter int CONF_DEPTH = 32,
    parameter int NUM_SM     = 4,
    localparam int PW        = $clog2(PROG_DEPTH),
    localparam int CW        = $clog2(CONF_DEPTH),
    localparam int SW        = $clog2(NUM_SM),
    localparam int CONF_W    = 37 + SW
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [PW:0]       prog_len,
    input  logic [CW:0]       conf_len,
    output logic [PW-1:0]     prog_rd_addr,
    input  logic [15:0]       prog_rd_data,
    output logic [CW-1:0]     conf_rd_addr,
    input  logic [CONF_W-1:0] conf_rd_data,
    output logic [3:0]        action,
    output logic [31:0]       din,
    output logic [4:0]        index,
    output logic [SW-1:0]     mindex,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROG,
        S_CONF,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam logic [PW:0]   PROG_MAX = (PW+1)'(PROG_DEPTH);
    localparam logic [CW:0]   CONF_MAX = (CW+1)'(CONF_DEPTH);
    localparam logic [SW-1:0] REP_LAST = SW'(NUM_SM - 1);

    state_t              state_q, state_d;
    logic [PW-1:0]       prog_cnt_q, prog_cnt_d;
    logic [CW-1:0]       conf_cnt_q, conf_cnt_d;
    logic [PW:0]         prog_len_q, prog_len_d;
    logic [CW:0]         conf_len_q, conf_len_d;
    // Read stage: a word is arriving from memory this cycle.
    logic                v1_q, v1_d;
    // The arriving word is a config entry; when clear it is a program word.
    logic                k1_q, k1_d;
    // Program index of the arriving word.
    logic [PW-1:0]       a1_q, a1_d;
    // Broadcast replica number and the captured broadcast entry.
    logic [SW-1:0]       rep_q, rep_d;
    logic [CONF_W-1:0]   hold_q, hold_d;
    logic [3:0]          action_q, action_d;
    logic [31:0]         din_q, din_d;
    logic [4:0]          index_q, index_d;
    logic [SW-1:0]       mindex_q, mindex_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [PW:0]         prog_len_clamp;
    logic [CW:0]         conf_len_clamp;
    logic [CONF_W-1:0]   cur_entry;
    logic                cur_bcast;
    logic                last_rep;
    logic                stall;
    logic                prog_last;
    logic                conf_last;

    // Requested lengths limited to what the memories can hold.
    assign prog_len_clamp = (prog_len > PROG_MAX) ? PROG_MAX : prog_len;
    assign conf_len_clamp = (conf_len > CONF_MAX) ? CONF_MAX : conf_len;

    // The first replica uses the live read data; later replicas come from
    // hold_q, because the memory has already moved on to the next address.
    assign cur_entry = (rep_q != '0) ? hold_q : conf_rd_data;
    assign cur_bcast = cur_entry[CONF_W-1];
    assign last_rep  = (rep_q == REP_LAST);
    assign stall     = v1_q && k1_q && cur_bcast && !last_rep;

    assign prog_last = (({1'b0, prog_cnt_q} + (PW+1)'(1)) == prog_len_q);
    assign conf_last = (({1'b0, conf_cnt_q} + (CW+1)'(1)) == conf_len_q);

    // Next-state, address issue, broadcast replay and output-stage logic.
    always_comb begin
        state_d    = state_q;
        prog_cnt_d = prog_cnt_q;
        conf_cnt_d = conf_cnt_q;
        prog_len_d = prog_len_q;
        conf_len_d = conf_len_q;
        v1_d       = stall;
        k1_d       = k1_q;
        a1_d       = a1_q;
        rep_d      = rep_q;
        hold_d     = hold_q;
        action_d   = 4'd0;
        din_d      = 32'd0;
        index_d    = 5'd0;
        mindex_d   = '0;

        // Output stage: turn the word arriving this cycle into a load command.
        if (v1_q) begin
            if (!k1_q) begin
                action_d = 4'd1;
                din_d    = {16'b0, prog_rd_data};
                index_d  = 5'(a1_q);
            end else begin
                action_d = cur_entry[35:32];
                din_d    = cur_entry[31:0];
                mindex_d = cur_bcast ? rep_q : cur_entry[35+SW:36];
                if (cur_bcast) begin
                    if (rep_q == '0) begin
                        hold_d = conf_rd_data;
                    end
                    rep_d = last_rep ? '0 : rep_q + SW'(1);
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    prog_len_d = prog_len_clamp;
                    conf_len_d = conf_len_clamp;
                    prog_cnt_d = '0;
                    conf_cnt_d = '0;
                    if (prog_len_clamp != '0) begin
                        state_d = S_PROG;
                    end else if (conf_len_clamp != '0) begin
                        state_d = S_CONF;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_PROG: begin
                v1_d = 1'b1;
                k1_d = 1'b0;
                a1_d = prog_cnt_q;
                if (prog_last) begin
                    state_d = (conf_len_q != '0) ? S_CONF : S_DRAIN;
                end else begin
                    prog_cnt_d = prog_cnt_q + PW'(1);
                end
            end
            S_CONF: begin
                // While a broadcast is replayed the address stays put and
                // is reissued once the final replica goes out.
                if (!stall) begin
                    v1_d = 1'b1;
                    k1_d = 1'b1;
                    if (conf_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        conf_cnt_d = conf_cnt_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // The last word reaches the outputs in the cycle the read
                // stage empties, so completion follows immediately after.
                if (!v1_q) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops everything in flight and reports no completion.
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            v1_d     = 1'b0;
            rep_d    = '0;
            action_d = 4'd0;
            din_d    = 32'd0;
            index_d  = 5'd0;
            mindex_d = '0;
        end

        busy_d = (state_d == S_PROG) || (state_d == S_CONF) || (state_d == S_DRAIN);
        done_d = (state_d == S_FIN);
    end

    // State and registered outputs, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            prog_cnt_q <= '0;
            conf_cnt_q <= '0;
            prog_len_q <= '0;
            conf_len_q <= '0;
            v1_q       <= 1'b0;
            k1_q       <= 1'b0;
            a1_q       <= '0;
            rep_q      <= '0;
            hold_q     <= '0;
            action_q   <= 4'd0;
            din_q      <= 32'd0;
            index_q    <= 5'd0;
            mindex_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_cnt_q <= prog_cnt_d;
            conf_cnt_q <= conf_cnt_d;
            prog_len_q <= prog_len_d;
            conf_len_q <= conf_len_d;
            v1_q       <= v1_d;
            k1_q       <= k1_d;
            a1_q       <= a1_d;
            rep_q      <= rep_d;
            hold_q     <= hold_d;
            action_q   <= action_d;
            din_q      <= din_d;
            index_q    <= index_d;
            mindex_q   <= mindex_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign prog_rd_addr = prog_cnt_q;
    assign conf_rd_addr = conf_cnt_q;
    assign action       = action_q;
    assign din          = din_q;
    assign index        = index_q;
    assign mindex       = mindex_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_pio_loader.sv
// Table-driven bench for pio_loader. Each scenario fills a per-cycle table of
// {inputs, expected outputs}, then replays it against the DUT. Inputs are
// applied just after the rising edge and outputs are checked on the falling
// edge. Cycle 0 of every table is the cycle in which start is first raised.
module tb_pio_loader;

    localparam int PD     = 32;
    localparam int CD     = 32;
    localparam int NSM    = 4;
    localparam int PW     = 5;
    localparam int CW     = 5;
    localparam int SW     = 2;
    localparam int CONF_W = 37 + SW;
    localparam int GW     = 4 + 32 + 5 + SW + 2;
    localparam int NV     = 64;

    logic              clk = 1'b0;
    logic              n_reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [PW:0]       prog_len = '0;
    logic [CW:0]       conf_len = '0;
    logic [PW-1:0]     prog_rd_addr;
    logic [15:0]       prog_rd_data = '0;
    logic [CW-1:0]     conf_rd_addr;
    logic [CONF_W-1:0] conf_rd_data = '0;
    logic [3:0]        action;
    logic [31:0]       din;
    logic [4:0]        index;
    logic [SW-1:0]     mindex;
    logic              busy;
    logic              done;

    pio_loader #(.PROG_DEPTH(PD), .CONF_DEPTH(CD), .NUM_SM(NSM)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .abort(abort),
        .prog_len(prog_len), .conf_len(conf_len),
        .prog_rd_addr(prog_rd_addr), .prog_rd_data(prog_rd_data),
        .conf_rd_addr(conf_rd_addr), .conf_rd_data(conf_rd_data),
        .action(action), .din(din), .index(index), .mindex(mindex),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Bench-side synchronous memories with one-cycle read latency.
    logic [15:0]       prog_mem [PD];
    logic [CONF_W-1:0] conf_mem [CD];
    always @(posedge clk) begin
        prog_rd_data <= prog_mem[prog_rd_addr];
        conf_rd_data <= conf_mem[conf_rd_addr];
    end

    // Field values of the basic config list.
    logic [SW-1:0] c_mi  [5];
    logic [3:0]    c_act [5];
    logic [31:0]   c_din [5];

    typedef struct {
        logic          rst_n;
        logic          start;
        logic          abort;
        logic [3:0]    act;
        logic [31:0]   din;
        logic [4:0]    idx;
        logic [SW-1:0] mi;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t vec [NV];
    int checks = 0;
    int errors = 0;

    task automatic clear_out(input int c);
        vec[c].act  = '0;
        vec[c].din  = '0;
        vec[c].idx  = '0;
        vec[c].mi   = '0;
        vec[c].busy = 1'b0;
        vec[c].done = 1'b0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NV; i++) begin
            vec[i].rst_n = 1'b1;
            vec[i].start = 1'b0;
            vec[i].abort = 1'b0;
            clear_out(i);
        end
    endtask

    task automatic set_word(input int c, input logic [3:0] a, input logic [31:0] d,
                            input logic [4:0] ix, input logic [SW-1:0] m);
        vec[c].act = a;
        vec[c].din = d;
        vec[c].idx = ix;
        vec[c].mi  = m;
    endtask

    task automatic set_busy(input int from, input int to);
        for (int c = from; c <= to; c++) vec[c].busy = 1'b1;
    endtask

    // Expected trace of the 12-word program plus 5-entry config load,
    // with start raised in cycle off.
    task automatic fill_basic(input int off);
        vec[off].start = 1'b1;
        set_busy(off + 1, off + 19);
        for (int i = 0; i < 12; i++)
            set_word(off + 3 + i, 4'd1, {16'b0, prog_mem[i]}, 5'(i), '0);
        for (int j = 0; j < 5; j++)
            set_word(off + 15 + j, c_act[j], c_din[j], 5'd0, c_mi[j]);
        vec[off + 20].done = 1'b1;
    endtask

    // Replay cycles 0..n-1 of the table and compare each cycle.
    task automatic run(input string name, input int n);
        logic [GW-1:0] got, exp;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            n_reset = vec[c].rst_n;
            start   = vec[c].start;
            abort   = vec[c].abort;
            @(negedge clk);
            got = {action, din, index, mindex, busy, done};
            exp = {vec[c].act, vec[c].din, vec[c].idx, vec[c].mi, vec[c].busy, vec[c].done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cyc %0d: got act=%0h din=%h idx=%0d mi=%0d busy=%b done=%b, want act=%0h din=%h idx=%0d mi=%0d busy=%b done=%b",
                         name, c, action, din, index, mindex, busy, done,
                         vec[c].act, vec[c].din, vec[c].idx, vec[c].mi, vec[c].busy, vec[c].done);
            end
        end
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < PD; i++) prog_mem[i] = 16'hA000 ^ 16'(i * 16'h0107);
        for (int i = 0; i < CD; i++) conf_mem[i] = '0;
        c_mi[0] = 2'd3; c_mi[1] = 2'd1; c_mi[2] = 2'd2; c_mi[3] = 2'd0; c_mi[4] = 2'd3;
        c_act[0] = 4'h2; c_act[1] = 4'h3; c_act[2] = 4'h4; c_act[3] = 4'h5; c_act[4] = 4'h7;
        for (int j = 0; j < 5; j++) begin
            c_din[j]    = 32'hC0DE_0000 + 32'(j);
            conf_mem[j] = {1'b0, c_mi[j], c_act[j], c_din[j]};
        end

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({action, din, index, mindex, busy, done, prog_rd_addr, conf_rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset: got act=%0h din=%h idx=%0d mi=%0d busy=%b done=%b pa=%0d ca=%0d, want all 0",
                     action, din, index, mindex, busy, done, prog_rd_addr, conf_rd_addr);
        end

        // Basic load.
        prog_len = 6'd12;
        conf_len = 6'd5;
        clear_all();
        fill_basic(0);
        run("basic", 22);

        // Start held high while busy: the trace is unchanged.
        clear_all();
        fill_basic(0);
        for (int c = 0; c < 20; c++) vec[c].start = 1'b1;
        run("restart_held", 22);

        // Abort in cycle 8, then a fresh start in cycle 10.
        clear_all();
        fill_basic(0);
        for (int c = 9; c < NV; c++) clear_out(c);
        vec[8].abort = 1'b1;
        fill_basic(10);
        run("abort", 32);

        // Reset pulse in cycle 6.
        clear_all();
        fill_basic(0);
        for (int c = 7; c < NV; c++) clear_out(c);
        vec[6].rst_n = 1'b0;
        run("mid_reset", 12);

        // Single broadcast entry, no program.
        conf_mem[0] = {1'b1, 2'd2, 4'h6, 32'h1};
        conf_mem[1] = {1'b0, 2'd1, 4'h9, 32'h55AA};
        prog_len = 6'd0;
        conf_len = 6'd1;
        clear_all();
        vec[0].start = 1'b1;
        set_busy(1, 6);
        for (int r = 0; r < NSM; r++) set_word(3 + r, 4'h6, 32'h1, 5'd0, SW'(r));
        vec[7].done = 1'b1;
        run("bcast", 9);

        // Broadcast followed by a normal entry: no gap after the last replica.
        conf_len = 6'd2;
        clear_all();
        vec[0].start = 1'b1;
        set_busy(1, 7);
        for (int r = 0; r < NSM; r++) set_word(3 + r, 4'h6, 32'h1, 5'd0, SW'(r));
        set_word(7, 4'h9, 32'h55AA, 5'd0, 2'd1);
        vec[8].done = 1'b1;
        run("bcast_then_entry", 10);

        // Both lengths zero.
        prog_len = 6'd0;
        conf_len = 6'd0;
        clear_all();
        vec[0].start = 1'b1;
        vec[1].done  = 1'b1;
        run("zero_len", 4);

        // Program length above the depth is clamped to 32 words.
        prog_len = 6'd40;
        conf_len = 6'd0;
        clear_all();
        vec[0].start = 1'b1;
        set_busy(1, 34);
        for (int i = 0; i < PD; i++)
            set_word(3 + i, 4'd1, {16'b0, prog_mem[i]}, 5'(i), '0);
        vec[35].done = 1'b1;
        run("clamp", 37);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on the run time.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, want $finish before 100000");
        $fatal(1);
    end

endmodule
